// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with configurable framing.
// The tx line is registered from the current state, so it trails the FSM by exactly one cycle.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS = 8,
    parameter int PARITY = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_BITS-1:0]                 wr_data,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    output logic                                 tx,
    output logic                                 busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] BIT_LD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LD = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] shreg;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_idx;
    logic                 push, pop, par_bit, tx_next;

    assign wr_ready = fifo_count != CW'(FIFO_DEPTH);
    assign push = wr_valid && wr_ready;
    assign pop = fifo_count != '0 && (state == S_IDLE || (state == S_STOP && timer == '0));
    assign busy = state != S_IDLE || fifo_count != '0;
    assign par_bit = PARITY == 1 ? ~^shreg : ^shreg;

    always_comb tx_next = state == S_START ? 1'b0 :
                          state == S_DATA ? shreg[bit_idx] :
                          state == S_PARITY ? par_bit : 1'b1;

    always_ff @(posedge clk)
        if (push && !rst) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            timer <= '0;
            bit_idx <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            shreg <= '0;
            tx <= 1'b1;
        end else begin
            tx <= tx_next;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                shreg <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (state)
                S_IDLE:
                    if (pop) begin
                        state <= S_START;
                        timer <= BIT_LD;
                    end
                S_START:
                    if (timer == '0) begin
                        state <= S_DATA;
                        timer <= BIT_LD;
                        bit_idx <= '0;
                    end else timer <= timer - 1'b1;
                S_DATA:
                    if (timer != '0) timer <= timer - 1'b1;
                    else if (bit_idx != LAST_BIT) begin
                        bit_idx <= bit_idx + 1'b1;
                        timer <= BIT_LD;
                    end else begin
                        state <= PARITY != 0 ? S_PARITY : S_STOP;
                        timer <= PARITY != 0 ? BIT_LD : STOP_LD;
                    end
                S_PARITY:
                    if (timer == '0) begin
                        state <= S_STOP;
                        timer <= STOP_LD;
                    end else timer <= timer - 1'b1;
                S_STOP:
                    if (timer != '0) timer <= timer - 1'b1;
                    else if (pop) begin
                        state <= S_START;
                        timer <= BIT_LD;
                    end else state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four differently configured transmitters checked against a
// per-cycle line model built from the framing rules (start, LSB-first data, parity, stop).
module tb_uart_tx_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] wd [4];
    logic [3:0] wv = '0;
    wire  [3:0] rdy, txs, bsy;
    wire  [2:0] cnt [4];
    int checks = 0;
    int errors = 0;
    int db_cfg [4] = '{8, 8, 8, 5};
    int par_cfg [4] = '{2, 1, 0, 0};
    int sb_cfg [4] = '{1, 1, 1, 2};
    logic expq [$];
    logic cap [$];

    always #5 clk = ~clk;

    uart_tx_param #(.PARITY(2)) dut_e (.clk(clk), .rst(rst), .wr_data(wd[0]), .wr_valid(wv[0]),
        .wr_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]), .fifo_count(cnt[0]));
    uart_tx_param #(.PARITY(1)) dut_o (.clk(clk), .rst(rst), .wr_data(wd[1]), .wr_valid(wv[1]),
        .wr_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]), .fifo_count(cnt[1]));
    uart_tx_param #(.PARITY(0)) dut_n (.clk(clk), .rst(rst), .wr_data(wd[2]), .wr_valid(wv[2]),
        .wr_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]), .fifo_count(cnt[2]));
    uart_tx_param #(.DATA_BITS(5), .STOP_BITS(2)) dut_5 (.clk(clk), .rst(rst), .wr_data(wd[3][4:0]),
        .wr_valid(wv[3]), .wr_ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]), .fifo_count(cnt[3]));

    // Expected line level for every clock of one frame, appended to expq.
    function automatic void model_frame(int s, logic [7:0] w);
        logic lv [$];
        logic p;
        p = 1'b0;
        lv.push_back(1'b0);
        for (int i = 0; i < db_cfg[s]; i++) begin
            lv.push_back(w[i]);
            p ^= w[i];
        end
        if (par_cfg[s] != 0) lv.push_back(par_cfg[s] == 1 ? ~p : p);
        for (int i = 0; i < sb_cfg[s]; i++) lv.push_back(1'b1);
        foreach (lv[b]) repeat (4) expq.push_back(lv[b]);
    endfunction

    task automatic push(int s, logic [7:0] w);
        bit ok = 1'b0;
        wd[s] = w;
        wv[s] = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = rdy[s];
            @(negedge clk);
        end
        wv[s] = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout s%0d: wr_ready stayed 0, expected 1", s);
        end
    endtask

    task automatic wait_fall(int s, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (txs[s] !== 1'b0 && n < 300);
        if (txs[s] !== 1'b0) begin
            errors++;
            $display("FAIL start_timeout s%0d: tx=%b, expected 0", s, txs[s]);
        end
    endtask

    task automatic capture(int s, int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            cap.push_back(txs[s]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 4; s++) wd[s] = 8'($urandom);
        wv = '1;
        repeat (3) @(negedge clk);
        wv = '0;
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (txs[s] !== 1'b1 || bsy[s] !== 1'b0 || cnt[s] !== 3'd0 || rdy[s] !== 1'b1) begin
                errors++;
                $display("FAIL reset s%0d: tx=%b busy=%b count=%0d ready=%b, expected 1 0 0 1",
                         s, txs[s], bsy[s], cnt[s], rdy[s]);
            end
        end
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (cnt[s] !== 3'd0 || bsy[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_push_discard s%0d: count=%0d busy=%b, expected 0 0", s, cnt[s], bsy[s]);
            end
        end
    endtask

    task automatic test_parity_even();
        int n;
        expq.delete();
        cap.delete();
        model_frame(0, 8'hA5);
        push(0, 8'hA5);
        wait_fall(0, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL latency: tx fell %0d cycles after accept, expected 2", n);
        end
        checks++;
        if (bsy[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_frame: busy=%b, expected 1", bsy[0]);
        end
        capture(0, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (cap[i] !== expq[i]) begin
                errors++;
                $display("FAIL even_frame cycle %0d: tx=%b expected %b", i, cap[i], expq[i]);
            end
        end
        checks++;
        if (cap[36] !== 1'b0) begin
            errors++;
            $display("FAIL even_parity_a5: parity=%b, expected 0", cap[36]);
        end
        @(negedge clk);
        checks++;
        if (txs[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL even_after: tx=%b busy=%b, expected 1 0", txs[0], bsy[0]);
        end
    endtask

    task automatic test_parity_odd();
        int n;
        logic [7:0] wl [2] = '{8'h01, 8'h03};
        logic pl [2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            expq.delete();
            cap.delete();
            model_frame(1, wl[k]);
            push(1, wl[k]);
            wait_fall(1, n);
            capture(1, expq.size());
            for (int i = 0; i < expq.size(); i++) begin
                checks++;
                if (cap[i] !== expq[i]) begin
                    errors++;
                    $display("FAIL odd_frame %h cycle %0d: tx=%b expected %b", wl[k], i, cap[i], expq[i]);
                end
            end
            checks++;
            if (cap[36] !== pl[k]) begin
                errors++;
                $display("FAIL odd_parity %h: parity=%b, expected %b", wl[k], cap[36], pl[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_no_parity();
        int n;
        logic [7:0] w = 8'($urandom);
        expq.delete();
        cap.delete();
        model_frame(2, w);
        push(2, w);
        wait_fall(2, n);
        capture(2, 41);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (cap[i] !== expq[i]) begin
                errors++;
                $display("FAIL nopar_frame %h cycle %0d: tx=%b expected %b", w, i, cap[i], expq[i]);
            end
        end
        checks++;
        if (cap[40] !== 1'b1 || bsy[2] !== 1'b0) begin
            errors++;
            $display("FAIL nopar_length: tx=%b busy=%b after 40 cycles, expected 1 0", cap[40], bsy[2]);
        end
    endtask

    task automatic test_five_bit();
        int n;
        expq.delete();
        cap.delete();
        model_frame(3, 8'h1F);
        push(3, 8'h1F);
        wait_fall(3, n);
        capture(3, 33);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap[i] !== expq[i]) begin
                errors++;
                $display("FAIL five_bit cycle %0d: tx=%b expected %b", i, cap[i], expq[i]);
            end
        end
        checks++;
        if (bsy[3] !== 1'b0 || cap[32] !== 1'b1) begin
            errors++;
            $display("FAIL five_bit_end: busy=%b tx=%b, expected 0 1", bsy[3], cap[32]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [6];
        bit saw_full = 1'b0;
        expq.delete();
        cap.delete();
        for (int i = 0; i < 6; i++) begin
            w[i] = 8'($urandom);
            model_frame(2, w[i]);
        end
        fork
            for (int i = 0; i < 6; i++) push(2, w[i]);
            begin
                int n;
                wait_fall(2, n);
                capture(2, expq.size());
            end
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (rdy[2] === 1'b0) begin
                    saw_full = 1'b1;
                    checks++;
                    if (cnt[2] !== 3'd4) begin
                        errors++;
                        $display("FAIL full_count: ready=0 with count=%0d, expected 4", cnt[2]);
                    end
                end
            end
        join
        checks++;
        if (!saw_full) begin
            errors++;
            $display("FAIL full_seen: wr_ready never 0, expected 0 while frame 1 in flight");
        end
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (cap[i] !== expq[i]) begin
                errors++;
                $display("FAIL b2b cycle %0d: tx=%b expected %b", i, cap[i], expq[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (txs[2] !== 1'b1 || bsy[2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: tx=%b busy=%b, expected 1 0", txs[2], bsy[2]);
        end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] w [4];
        expq.delete();
        cap.delete();
        for (int i = 0; i < 4; i++) begin
            w[i] = 8'($urandom);
            model_frame(2, w[i]);
        end
        fork
            begin
                push(2, w[0]);
                push(2, w[1]);
                push(2, w[2]);
                repeat (38) @(negedge clk);
                checks++;
                if (cnt[2] !== 3'd2) begin
                    errors++;
                    $display("FAIL simul_before: count=%0d, expected 2", cnt[2]);
                end
                push(2, w[3]);
                checks++;
                if (cnt[2] !== 3'd2) begin
                    errors++;
                    $display("FAIL simul_after: count=%0d, expected 2", cnt[2]);
                end
            end
            begin
                int n;
                wait_fall(2, n);
                capture(2, expq.size());
            end
        join
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (cap[i] !== expq[i]) begin
                errors++;
                $display("FAIL simul_frames cycle %0d: tx=%b expected %b", i, cap[i], expq[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int sel [3] = '{0, 1, 3};
        for (int k = 0; k < 3; k++) begin
            int s = sel[k];
            int fl = 4 * (1 + db_cfg[s] + (par_cfg[s] != 0 ? 1 : 0) + sb_cfg[s]);
            logic [7:0] w [5];
            expq.delete();
            cap.delete();
            for (int i = 0; i < 5; i++) begin
                w[i] = 8'($urandom);
                model_frame(s, w[i]);
            end
            fork
                for (int i = 0; i < 5; i++) begin
                    repeat ($urandom_range(0, 50)) @(negedge clk);
                    push(s, w[i]);
                end
                for (int i = 0; i < 5; i++) begin
                    int n;
                    wait_fall(s, n);
                    capture(s, fl);
                end
            join
            for (int i = 0; i < expq.size(); i++) begin
                checks++;
                if (cap[i] !== expq[i]) begin
                    errors++;
                    $display("FAIL random s%0d cycle %0d: tx=%b expected %b", s, i, cap[i], expq[i]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midframe();
        int bad = 0;
        logic [7:0] w0 = 8'($urandom);
        push(2, w0);
        push(2, 8'($urandom));
        push(2, 8'($urandom));
        repeat (16) @(negedge clk);
        checks++;
        if (cnt[2] !== 3'd2 || txs[2] !== w0[3]) begin
            errors++;
            $display("FAIL midframe_pre: count=%0d tx=%b, expected 2 %b", cnt[2], txs[2], w0[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (txs[2] !== 1'b1 || cnt[2] !== 3'd0 || bsy[2] !== 1'b0 || rdy[2] !== 1'b1) begin
            errors++;
            $display("FAIL midframe_reset: tx=%b count=%0d busy=%b ready=%b, expected 1 0 0 1",
                     txs[2], cnt[2], bsy[2], rdy[2]);
        end
        repeat (60) begin
            @(negedge clk);
            if (txs[2] !== 1'b1 || bsy[2] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midframe_quiet: %0d active cycles after reset, expected 0", bad);
        end
    endtask

    initial begin
        for (int s = 0; s < 4; s++) wd[s] = '0;
        test_reset();
        test_parity_even();
        test_parity_odd();
        test_no_parity();
        test_five_bit();
        test_back_to_back();
        test_simul_push_pop();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
